// File: rtl/uart_access_arbiter_if.sv
// rtl/uart_access_arbiter_if.sv - pulse-request/busy handshake shared by uartAccess clients
// The master issues requests; the slave reports busy, read data and status.
interface uart_access_arbiter_if;
   logic       accessReq;
   logic       readNotWrite;
   logic [7:0] dataIn;
   logic       timeOutEnable;
   logic       busy;
   logic [7:0] dataOut;
   logic       timeOut;
   logic       error;

   modport master (
      output accessReq, readNotWrite, dataIn, timeOutEnable,
      input  busy, dataOut, timeOut
   );

   modport slave (
      input  accessReq, readNotWrite, dataIn, timeOutEnable,
      output busy, dataOut, timeOut, error
   );
endinterface

// File: rtl/uart_access_arbiter.sv
// rtl/uart_access_arbiter.sv - round-robin sharing of one uartAccess between two clients
// Each client holds one latched request; the FSM sequences the downstream handshake.
module uart_access_arbiter #(
   parameter int                    GUARD_CYCLES = 1,
   parameter int                    WDOG_WIDTH   = 16,
   parameter logic [WDOG_WIDTH-1:0] WDOG_LIMIT   = 16'hFFFF
) (
   input  logic                  clk,
   input  logic                  rst,
   uart_access_arbiter_if.slave  a,
   uart_access_arbiter_if.slave  b,
   uart_access_arbiter_if.master down
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] ISSUE     = 3'd1;
   localparam logic [2:0] GUARD     = 3'd2;
   localparam logic [2:0] WAIT_DONE = 3'd3;
   localparam logic [2:0] DONE      = 3'd4;

   localparam logic [7:0] GUARD_LAST = 8'(GUARD_CYCLES - 1);

   logic [2:0]            state;
   logic                  grantB;
   logic                  rrPtrB;
   logic [7:0]            guardCnt;
   logic [WDOG_WIDTH-1:0] wdogCnt;

   logic       aPend, aRnw, aToe;
   logic [7:0] aData;
   logic       bPend, bRnw, bToe;
   logic [7:0] bData;

   logic [7:0] aDataOut, bDataOut;
   logic       aTimeOut, bTimeOut, aError, bError;

   logic       aDone, bDone, aBusy, bBusy, aCap, bCap;
   logic       inTxn, doneOk, wdogTrip, finish;
   logic [7:0] resData;
   logic       resTo;

   // busy drops during DONE so the client can re-request in that same cycle
   assign aDone = (state == DONE) && !grantB;
   assign bDone = (state == DONE) && grantB;
   assign aBusy = aPend && !aDone;
   assign bBusy = bPend && !bDone;
   assign aCap  = a.accessReq && !aBusy;
   assign bCap  = b.accessReq && !bBusy;

   assign a.busy    = aBusy;
   assign a.dataOut = aDataOut;
   assign a.timeOut = aTimeOut;
   assign a.error   = aError;
   assign b.busy    = bBusy;
   assign b.dataOut = bDataOut;
   assign b.timeOut = bTimeOut;
   assign b.error   = bError;

   assign inTxn              = (state != IDLE);
   assign down.accessReq     = (state == ISSUE);
   assign down.readNotWrite  = inTxn && (grantB ? bRnw : aRnw);
   assign down.timeOutEnable = inTxn && (grantB ? bToe : aToe);
   assign down.dataIn        = inTxn ? (grantB ? bData : aData) : 8'h00;

   assign doneOk   = (state == WAIT_DONE) && !down.busy;
   assign wdogTrip = (state == WAIT_DONE) && down.busy && (WDOG_LIMIT != '0) &&
                     (wdogCnt == WDOG_LIMIT - 1'b1);
   assign finish   = doneOk || wdogTrip;
   assign resData  = wdogTrip ? 8'h00 : down.dataOut;
   assign resTo    = wdogTrip || down.timeOut;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         aPend <= 1'b0;
         aRnw  <= 1'b0;
         aToe  <= 1'b0;
         aData <= 8'h00;
         bPend <= 1'b0;
         bRnw  <= 1'b0;
         bToe  <= 1'b0;
         bData <= 8'h00;
      end else begin
         if (aCap) begin
            aPend <= 1'b1;
            aRnw  <= a.readNotWrite;
            aToe  <= a.timeOutEnable;
            aData <= a.dataIn;
         end else if (aDone) begin
            aPend <= 1'b0;
         end
         if (bCap) begin
            bPend <= 1'b1;
            bRnw  <= b.readNotWrite;
            bToe  <= b.timeOutEnable;
            bData <= b.dataIn;
         end else if (bDone) begin
            bPend <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         grantB   <= 1'b0;
         rrPtrB   <= 1'b0;
         guardCnt <= 8'h00;
         wdogCnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               // the pointer only advances when both clients contend
               if (aPend && bPend) begin
                  grantB <= rrPtrB;
                  rrPtrB <= !rrPtrB;
                  state  <= ISSUE;
               end else if (aPend) begin
                  grantB <= 1'b0;
                  state  <= ISSUE;
               end else if (bPend) begin
                  grantB <= 1'b1;
                  state  <= ISSUE;
               end
            end
            ISSUE: begin
               guardCnt <= 8'h00;
               state    <= GUARD;
            end
            GUARD: begin
               if (guardCnt == GUARD_LAST) begin
                  wdogCnt <= '0;
                  state   <= WAIT_DONE;
               end else begin
                  guardCnt <= guardCnt + 8'h01;
               end
            end
            WAIT_DONE: begin
               if (finish) begin
                  state <= DONE;
               end else begin
                  wdogCnt <= wdogCnt + 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         aDataOut <= 8'h00;
         aTimeOut <= 1'b0;
         aError   <= 1'b0;
         bDataOut <= 8'h00;
         bTimeOut <= 1'b0;
         bError   <= 1'b0;
      end else if (finish) begin
         if (grantB) begin
            bDataOut <= resData;
            bTimeOut <= resTo;
            bError   <= wdogTrip;
         end else begin
            aDataOut <= resData;
            aTimeOut <= resTo;
            aError   <= wdogTrip;
         end
      end
   end

endmodule

// File: doc/uart_access_arbiter.md
Name: uart_access_arbiter

Overview:
Two-client arbiter that shares one uartAccess instance, and through it the single wishbone UART, between two independent masters. Port A is the host command/response path; port B is the monitor capture-dump path. Each client port has the same pulse-request/busy handshake as uartAccess, so existing clients connect unchanged. The block queues one request per client, grants round-robin, sequences the downstream handshake and returns read data, timeout status and a watchdog error per transaction.

Parameters:
GUARD_CYCLES, 1, cycles after downstream accessReq before busy is sampled (downstream busy rises within this window).
WDOG_WIDTH, 16, width of the watchdog counter.
WDOG_LIMIT, 16'hFFFF, max cycles in WAIT_DONE before abort; 0 disables the watchdog.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
a_accessReq  in  1  client A request pulse (1 cycle)
a_readNotWrite  in  1  client A direction, sampled with a_accessReq
a_dataIn  in  8  client A write byte, sampled with a_accessReq
a_timeOutEnable  in  1  client A timeout enable, sampled with a_accessReq
a_busy  out  1  client A request pending or in service
a_dataOut  out  8  client A read byte, valid when a_busy falls
a_timeOut  out  1  client A timeout status of last transaction
a_error  out  1  client A watchdog abort on last transaction
b_*  same nine signals for client B
accessReq  out  1  downstream request pulse
readNotWrite  out  1  downstream direction
dataIn  out  8  downstream write byte
timeOutEnable  out  1  downstream timeout enable
busy  in  1  downstream busy
dataOut  in  8  downstream read byte
timeOut  in  1  downstream timeout flag

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; pending flags cleared; round-robin pointer = A (A wins first tie).
- Capture: x_accessReq=1 while x_pending=0 latches rnw/data/timeOutEnable and sets x_pending. x_busy = x_pending, so it goes high the cycle after the pulse.
- A pulse while x_pending=1 is ignored: no re-latch, no error. The client protocol forbids this.
- IDLE: if exactly one client is pending, grant it. If both are pending, grant the client the pointer names, then move the pointer to the other client. Go to ISSUE.
- ISSUE (1 cycle): accessReq=1; readNotWrite, dataIn and timeOutEnable driven from the granted latch. These stay stable until DONE. Go to GUARD.
- GUARD: count GUARD_CYCLES, clear the watchdog, go to WAIT_DONE.
- WAIT_DONE: when busy=0, register dataOut into x_dataOut and timeOut into x_timeOut, clear x_error, go to DONE.
  - Watchdog: if WDOG_LIMIT≠0 and the counter reaches WDOG_LIMIT with busy still 1, set x_error=1, set x_dataOut=8'h00 and x_timeOut=1, go to DONE.
- DONE (1 cycle): clear the granted client's x_pending, so x_busy falls this cycle with its data already valid. Go to IDLE.
- A new request can be granted the cycle after DONE.
- Request-to-ISSUE latency when idle: 2 cycles (capture, then IDLE decision).
- The other client may capture a request at any time, including the DONE cycle of its peer.
- x_dataOut, x_timeOut and x_error hold until that client's next completion.
- Downstream outputs are 0 outside ISSUE..DONE.
- rst asserted mid-transaction aborts it immediately: no completion is signalled and all pending requests are lost. The downstream uartAccess shares rst.

Test Plan:
- Single read on A, downstream returns 8'h5A with busy held 20 cycles → one accessReq pulse with readNotWrite=1; a_busy falls 1 cycle after busy falls; a_dataOut=8'h5A; b_busy stays 0.
- Simultaneous A write 8'h11 and B write 8'h22 after reset → A serviced first (dataIn=8'h11), then B (8'h22); repeat the tie → B serviced first.
- B pulses during A's WAIT_DONE → B captured (b_busy=1), granted the cycle after A's DONE; no lost or duplicated accessReq.
- Downstream busy stuck high, WDOG_LIMIT=16'd50 → after 50 WAIT_DONE cycles a_error=1, a_timeOut=1, a_dataOut=8'h00; next B request proceeds normally.
- Read with timeOutEnable=1, downstream timeOut=1 → a_timeOut=1, a_error=0.
- rst pulsed while in WAIT_DONE with both pending → all outputs 0, pointer=A; a fresh request completes normally.
